// File: rtl/rvfi_trace_tx_if.sv
// Signal bundle between a core's RVFI retirement port, the trace transmitter
// and the byte-stream sink it feeds.
interface rvfi_trace_tx_if;
  logic        rvfi_valid;
  logic [31:0] rvfi_pc_rdata;
  logic [31:0] rvfi_insn;
  logic [4:0]  rvfi_rd_addr;
  logic [31:0] rvfi_rd_wdata;
  logic        rvfi_intr;
  logic [1:0]  rvfi_mode;

  // Byte stream: a byte transfers on a posedge where tx_valid && tx_ready.
  // Once tx_valid rises, tx_valid/tx_data hold until that transfer happens.
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;

  // Current serializer state (0 = IDLE, 1 = SEND) for checkers and debug.
  logic        fsm_state;

  modport master (
    output rvfi_valid, rvfi_pc_rdata, rvfi_insn, rvfi_rd_addr, rvfi_rd_wdata,
           rvfi_intr, rvfi_mode, tx_ready,
    input  tx_valid, tx_data, fsm_state
  );

  modport slave (
    input  rvfi_valid, rvfi_pc_rdata, rvfi_insn, rvfi_rd_addr, rvfi_rd_wdata,
           rvfi_intr, rvfi_mode, tx_ready,
    output tx_valid, tx_data, fsm_state
  );
endinterface

// File: rtl/rvfi_trace_tx.sv
// Captures RVFI retirement records into a small FIFO and serializes each one
// as an 18-byte framed packet on an 8-bit valid/ready byte stream.
module rvfi_trace_tx #(
  parameter int unsigned DEPTH     = 4,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input  logic               clk,
  input  logic               reset,
  rvfi_trace_tx_if.slave     bus,
  output logic [15:0]        dropped_count,
  output logic [63:0]        order,
  output logic               busy
);
  localparam int unsigned AW   = $clog2(DEPTH);
  localparam int unsigned RW   = 121;
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;
  typedef logic [17:0][7:0] frame_t;

  // Record: {drop, intr, mode[1:0], rd_addr[4:0], order[15:0], pc, insn, rd_wdata}
  logic [RW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [AW:0]   count_d;
  logic          pending_drop;
  logic          push;
  logic          drop;
  logic          pop;

  state_t        state;
  state_t        state_d;
  frame_t        frame;
  frame_t        frame_d;
  logic [4:0]    byte_idx;
  logic [4:0]    byte_idx_d;
  logic          tx_valid_q;
  logic          tx_valid_d;
  logic [7:0]    tx_data_q;
  logic [7:0]    tx_data_d;

  function automatic frame_t build_frame(input logic [RW-1:0] r);
    frame_t     f;
    logic [7:0] x;
    f[0] = SYNC_BYTE;
    f[1] = {r[120], r[119], r[118:117], 4'b0000};
    f[2] = {3'b000, r[116:112]};
    f[3] = r[103:96];
    f[4] = r[111:104];
    for (int i = 0; i < 4; i++) begin
      f[5 + i]  = r[64 + 8*i +: 8];
      f[9 + i]  = r[32 + 8*i +: 8];
      f[13 + i] = r[8*i +: 8];
    end
    x = 8'h00;
    for (int i = 1; i < 17; i++) x = x ^ f[i];
    f[17] = x;
    return f;
  endfunction

  // Full/empty use the registered count: a pop in the same cycle never frees a slot.
  assign push    = bus.rvfi_valid && (count != FULL);
  assign drop    = bus.rvfi_valid && (count == FULL);
  assign pop     = (state == IDLE) && (count != '0);
  assign count_d = count + (AW+1)'(push) - (AW+1)'(pop);

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d    = state;
    byte_idx_d = byte_idx;
    frame_d    = frame;
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;
    case (state)
      IDLE: begin
        tx_valid_d = 1'b0;
        tx_data_d  = 8'h00;
        if (pop) begin
          frame_d    = build_frame(mem[rd_ptr]);
          byte_idx_d = 5'd0;
          state_d    = SEND;
          tx_valid_d = 1'b1;
          tx_data_d  = SYNC_BYTE;
        end
      end
      SEND: begin
        if (bus.tx_ready) begin
          if (byte_idx == 5'd17) begin
            state_d    = IDLE;
            tx_valid_d = 1'b0;
            tx_data_d  = 8'h00;
          end else begin
            byte_idx_d = byte_idx + 5'd1;
            tx_data_d  = frame[byte_idx_d];
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      byte_idx   <= '0;
      frame      <= '0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= 8'h00;
    end else begin
      byte_idx   <= byte_idx_d;
      frame      <= frame_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
    end
  end

  // Pointers wrap naturally at DEPTH because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      pending_drop  <= 1'b0;
      order         <= 64'd0;
      dropped_count <= 16'd0;
      busy          <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_d;
      order <= order + 64'(bus.rvfi_valid);
      if (drop) begin
        pending_drop <= 1'b1;
        if (dropped_count != 16'hFFFF) dropped_count <= dropped_count + 16'd1;
      end else if (push) begin
        pending_drop <= 1'b0;
      end
      busy <= (count_d != '0) || (state_d == SEND);
    end
  end

  always_ff @(posedge clk) begin
    if (reset && push)
      mem[wr_ptr] <= {pending_drop, bus.rvfi_intr, bus.rvfi_mode, bus.rvfi_rd_addr,
                      order[15:0], bus.rvfi_pc_rdata, bus.rvfi_insn, bus.rvfi_rd_wdata};
  end

  assign bus.tx_valid  = tx_valid_q;
  assign bus.tx_data   = tx_data_q;
  assign bus.fsm_state = state;
endmodule

// File: tb/tb_rvfi_trace_tx.sv
// Directed bench for rvfi_trace_tx: latency, frame contents, backpressure,
// overflow/drop flagging, back-to-back frames and reset behaviour.
module tb_rvfi_trace_tx;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] dropped_count;
  logic [63:0] order;
  logic        busy;

  int total  = 0;
  int passed = 0;
  int failed = 0;

  logic [7:0] fr [18];
  logic [7:0] exp_fr [18];

  rvfi_trace_tx_if bus ();

  rvfi_trace_tx #(.DEPTH(4), .SYNC_BYTE(8'hA5)) dut (
    .clk           (clk),
    .reset         (reset),
    .bus           (bus),
    .dropped_count (dropped_count),
    .order         (order),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: observed no end, expected finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    bus.rvfi_valid = 1'b0;
    bus.tx_ready = 1'b0;
    step();
    step();
    reset = 1'b1;
  endtask

  task automatic retire(input logic [31:0] pc, input logic [31:0] insn, input logic [4:0] rd,
                        input logic [31:0] wd, input logic [1:0] mode, input logic intr);
    bus.rvfi_pc_rdata = pc;
    bus.rvfi_insn     = insn;
    bus.rvfi_rd_addr  = rd;
    bus.rvfi_rd_wdata = wd;
    bus.rvfi_mode     = mode;
    bus.rvfi_intr     = intr;
    bus.rvfi_valid    = 1'b1;
    step();
    bus.rvfi_valid    = 1'b0;
  endtask

  task automatic wait_valid(input int bound);
    int i = 0;
    while (!bus.tx_valid && i < bound) begin
      step();
      i++;
    end
    check("wait_valid", bus.tx_valid, 1);
  endtask

  // Walks exp_fr byte by byte, optionally stalling tx_ready before byte stall_at.
  task automatic expect_frame(input string tag, input int stall_at, input int stall_len);
    bus.tx_ready = 1'b1;
    wait_valid(40);
    for (int k = 0; k < 18; k++) begin
      if (k == stall_at) begin
        bus.tx_ready = 1'b0;
        for (int s = 0; s < stall_len; s++) begin
          check($sformatf("%s_stall_valid%0d", tag, s), bus.tx_valid, 1);
          check($sformatf("%s_stall_data%0d", tag, s), bus.tx_data, exp_fr[k]);
          step();
        end
        bus.tx_ready = 1'b1;
      end
      check($sformatf("%s_byte%0d", tag, k), bus.tx_data, exp_fr[k]);
      step();
    end
    check($sformatf("%s_gap", tag), bus.tx_valid, 0);
  endtask

  task automatic recv_frame();
    bus.tx_ready = 1'b1;
    wait_valid(40);
    for (int k = 0; k < 18; k++) begin
      fr[k] = bus.tx_data;
      step();
    end
  endtask

  initial begin
    int seen;
    bus.rvfi_valid = 1'b0;
    bus.rvfi_pc_rdata = '0;
    bus.rvfi_insn = '0;
    bus.rvfi_rd_addr = '0;
    bus.rvfi_rd_wdata = '0;
    bus.rvfi_intr = 1'b0;
    bus.rvfi_mode = 2'd0;
    bus.tx_ready = 1'b0;

    // Reset state
    do_reset();
    check("rst_tx_valid", bus.tx_valid, 0);
    check("rst_tx_data", bus.tx_data, 0);
    check("rst_order", order, 0);
    check("rst_dropped", dropped_count, 0);
    check("rst_busy", busy, 0);

    // Single retire: latency and full frame
    exp_fr = '{8'hA5, 8'h30, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h80,
               8'h13, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hA3};
    bus.tx_ready = 1'b1;
    retire(32'h8000_0000, 32'h0000_0013, 5'd0, 32'h0, 2'd3, 1'b0);
    check("t1_valid_n1", bus.tx_valid, 0);
    check("t1_busy_n1", busy, 1);
    check("t1_order", order, 1);
    step();
    check("t1_valid_n2", bus.tx_valid, 1);
    expect_frame("t1", -1, 0);
    check("t1_busy_after", busy, 0);

    // Backpressure on byte 6 (order field now 1)
    exp_fr = '{8'hA5, 8'h30, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h80,
               8'h13, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hA2};
    retire(32'h8000_0000, 32'h0000_0013, 5'd0, 32'h0, 2'd3, 1'b0);
    expect_frame("t2", 6, 5);

    // Back-to-back retires: one idle cycle between frames
    do_reset();
    bus.tx_ready = 1'b1;
    retire(32'h0000_1000, 32'h00a0_0093, 5'd1, 32'h0000_000a, 2'd3, 1'b0);
    retire(32'h0000_1004, 32'h0010_0113, 5'd2, 32'h0000_0001, 2'd0, 1'b1);
    recv_frame();
    check("t4a_sync", fr[0], 8'hA5);
    check("t4a_flags", fr[1], 8'h30);
    check("t4a_rd", fr[2], 8'h01);
    check("t4a_order_lo", fr[3], 8'h00);
    check("t4a_order_hi", fr[4], 8'h00);
    check("t4a_csum", fr[17], 8'h18);
    check("t4_gap_valid", bus.tx_valid, 0);
    step();
    check("t4b_start_valid", bus.tx_valid, 1);
    check("t4b_start_data", bus.tx_data, 8'hA5);
    recv_frame();
    check("t4b_flags", fr[1], 8'h40);
    check("t4b_rd", fr[2], 8'h02);
    check("t4b_order_lo", fr[3], 8'h01);
    check("t4b_order_hi", fr[4], 8'h00);

    // Overflow: the frame register holds record 0, the FIFO holds 1..4, record 5 drops
    do_reset();
    bus.tx_ready = 1'b0;
    for (int i = 0; i < 6; i++)
      retire(32'h0000_2000 + 32'(4*i), 32'h0000_0013, 5'd3, 32'(i), 2'd3, 1'b0);
    check("t3_dropped_a", dropped_count, 1);
    check("t3_order_a", order, 6);
    recv_frame();
    check("t3_f0_order", fr[3], 8'h00);
    check("t3_f0_flags", fr[1], 8'h30);
    // FIFO still full while the IDLE cycle pops: this retire must be dropped
    retire(32'h0000_3000, 32'h0000_0013, 5'd3, 32'h0, 2'd3, 1'b0);
    check("t6b_dropped", dropped_count, 2);
    check("t6b_order", order, 7);
    for (int j = 1; j < 5; j++) begin
      recv_frame();
      check($sformatf("t3_f%0d_order", j), fr[3], 8'(j));
      check($sformatf("t3_f%0d_flags", j), fr[1], 8'h30);
    end
    check("t3_busy_drained", busy, 0);
    retire(32'h0000_4000, 32'h0000_0013, 5'd3, 32'h0, 2'd3, 1'b0);
    recv_frame();
    check("t3_after_drop_order", fr[3], 8'h07);
    check("t3_after_drop_flags", fr[1], 8'hB0);
    retire(32'h0000_4004, 32'h0000_0013, 5'd3, 32'h0, 2'd3, 1'b0);
    recv_frame();
    check("t3_next_order", fr[3], 8'h08);
    check("t3_next_flags", fr[1], 8'h30);
    check("t3_order_end", order, 9);

    // Reset during byte 9 with two records queued
    bus.tx_ready = 1'b1;
    retire(32'h0000_5000, 32'h1122_3344, 5'd4, 32'h0, 2'd3, 1'b0);
    retire(32'h0000_5004, 32'h1122_3344, 5'd4, 32'h0, 2'd3, 1'b0);
    retire(32'h0000_5008, 32'h1122_3344, 5'd4, 32'h0, 2'd3, 1'b0);
    for (int i = 0; i < 8; i++) step();
    check("t5_byte9", bus.tx_data, 8'h44);
    check("t5_busy_before", busy, 1);
    reset = 1'b0;
    step();
    check("t5_tx_valid", bus.tx_valid, 0);
    check("t5_tx_data", bus.tx_data, 0);
    check("t5_busy", busy, 0);
    check("t5_order", order, 0);
    check("t5_dropped", dropped_count, 0);
    reset = 1'b1;
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      if (bus.tx_valid || busy) seen++;
      step();
    end
    check("t5_silent", seen, 0);

    // Retire coincident with reset is ignored
    reset = 1'b0;
    bus.rvfi_valid = 1'b1;
    step();
    reset = 1'b1;
    bus.rvfi_valid = 1'b0;
    check("t6a_order", order, 0);
    check("t6a_busy", busy, 0);
    step();
    step();
    check("t6a_tx_valid", bus.tx_valid, 0);
    check("t6a_order_late", order, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
